// File: rtl/frv_pipeline_retire.sv
// Writeback/retire stage: GPR write port, load/CSR response wait, trap raise.
// Optional load bus timeout is compiled in with FRV_RETIRE_LD_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no instruction held
// WR       | held result/trap retires this cycle; may accept the next one
// WAIT_LD  | load held, waiting for dmem response (or timeout)
// WAIT_CSR | CSR op held, waiting for csr read data
module frv_pipeline_retire #(
  parameter int XLEN = 32
`ifdef FRV_RETIRE_LD_TIMEOUT_EN
  , parameter int LD_TIMEOUT = 255
`endif
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            s4_p_valid,
  output logic            s4_p_busy,
  input  logic [4:0]      s4_i_rd,
  input  logic [XLEN-1:0] s4_i_result,
  input  logic            s4_i_load,
  input  logic [1:0]      s4_i_lsize,
  input  logic            s4_i_lsign,
  input  logic            s4_i_csr,
  input  logic            s4_i_trap,
  input  logic [5:0]      s4_i_cause,
  input  logic [31:0]     s4_i_pc,
  input  logic            dmem_rvalid,
  input  logic            dmem_rerr,
  input  logic [31:0]     dmem_rdata,
  input  logic            csr_rvalid,
  input  logic [XLEN-1:0] csr_rdata,
  output logic [4:0]      s4_rd,
  output logic            s4_load,
  output logic            s4_csr,
  output logic            gpr_wen,
  output logic [4:0]      gpr_rd,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            trap_raise,
  output logic [5:0]      trap_cause,
  output logic [31:0]     trap_pc
);

  localparam logic [5:0] CAUSE_LD_FAULT = 6'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_WAIT_LD,
    ST_WAIT_CSR
  } state_t;

  state_t state, state_nxt;

  logic [4:0]      hold_rd;
  logic [XLEN-1:0] hold_result;
  logic [31:0]     hold_pc;
  logic [1:0]      hold_lsize;
  logic            hold_lsign;
  logic            hold_trap;
  logic [5:0]      hold_cause;

  logic            accept;
  logic            ld_timeout;
  logic [XLEN-1:0] ld_ext;

  assign s4_p_busy = (state == ST_WAIT_LD) || (state == ST_WAIT_CSR);
  assign accept    = s4_p_valid && !s4_p_busy;
  assign s4_load   = (state == ST_WAIT_LD);
  assign s4_csr    = (state == ST_WAIT_CSR);
  assign s4_rd     = (state == ST_IDLE) ? 5'd0 : hold_rd;

`ifdef FRV_RETIRE_LD_TIMEOUT_EN
  localparam logic [7:0] LD_TC = 8'(LD_TIMEOUT);
  logic [7:0] ld_cnt;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      ld_cnt <= 8'd0;
    end else if (accept) begin
      ld_cnt <= 8'd0;
    end else if (state == ST_WAIT_LD) begin
      ld_cnt <= ld_cnt + 8'd1;
    end
  end

  assign ld_timeout = (state == ST_WAIT_LD) && (ld_cnt == LD_TC);
`else
  assign ld_timeout = 1'b0;
`endif

  // Size cast of a signed operand sign-extends; unsigned zero-extends.
  always_comb begin
    ld_ext = '0;
    case (hold_lsize)
      2'b00:   ld_ext = hold_lsign ? XLEN'($signed(dmem_rdata[7:0]))
                                   : XLEN'(dmem_rdata[7:0]);
      2'b01:   ld_ext = hold_lsign ? XLEN'($signed(dmem_rdata[15:0]))
                                   : XLEN'(dmem_rdata[15:0]);
      default: ld_ext = hold_lsign ? XLEN'($signed(dmem_rdata))
                                   : XLEN'(dmem_rdata);
    endcase
  end

  always_comb begin
    state_nxt  = state;
    gpr_wen    = 1'b0;
    gpr_rd     = 5'd0;
    gpr_wdata  = '0;
    trap_raise = 1'b0;
    trap_cause = 6'd0;
    trap_pc    = 32'd0;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_IDLE;
      end
      ST_WR: begin
        if (hold_trap) begin
          trap_raise = 1'b1;
          trap_cause = hold_cause;
          trap_pc    = hold_pc;
        end else if (hold_rd != 5'd0) begin
          gpr_wen   = 1'b1;
          gpr_rd    = hold_rd;
          gpr_wdata = hold_result;
        end
        state_nxt = ST_IDLE;
      end
      ST_WAIT_LD: begin
        // A response on the timeout cycle takes precedence over the timeout.
        if (dmem_rvalid) begin
          if (dmem_rerr) begin
            trap_raise = 1'b1;
            trap_cause = CAUSE_LD_FAULT;
            trap_pc    = hold_pc;
          end else if (hold_rd != 5'd0) begin
            gpr_wen   = 1'b1;
            gpr_rd    = hold_rd;
            gpr_wdata = ld_ext;
          end
          state_nxt = ST_IDLE;
        end else if (ld_timeout) begin
          trap_raise = 1'b1;
          trap_cause = CAUSE_LD_FAULT;
          trap_pc    = hold_pc;
          state_nxt  = ST_IDLE;
        end
      end
      ST_WAIT_CSR: begin
        if (csr_rvalid) begin
          if (hold_rd != 5'd0) begin
            gpr_wen   = 1'b1;
            gpr_rd    = hold_rd;
            gpr_wdata = csr_rdata;
          end
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (accept) begin
      if (s4_i_trap)      state_nxt = ST_WR;
      else if (s4_i_load) state_nxt = ST_WAIT_LD;
      else if (s4_i_csr)  state_nxt = ST_WAIT_CSR;
      else                state_nxt = ST_WR;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state       <= ST_IDLE;
      hold_rd     <= 5'd0;
      hold_result <= '0;
      hold_pc     <= 32'd0;
      hold_lsize  <= 2'd0;
      hold_lsign  <= 1'b0;
      hold_trap   <= 1'b0;
      hold_cause  <= 6'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        hold_rd     <= s4_i_rd;
        hold_result <= s4_i_result;
        hold_pc     <= s4_i_pc;
        hold_lsize  <= s4_i_lsize;
        hold_lsign  <= s4_i_lsign;
        hold_trap   <= s4_i_trap;
        hold_cause  <= s4_i_cause;
      end
    end
  end

endmodule

// File: tb/tb_frv_pipeline_retire.sv
// Directed self-checking bench for frv_pipeline_retire; inputs change 1ns after the
// rising edge, outputs are checked mid-cycle.
module tb_frv_pipeline_retire;
  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        s4_p_valid;
  logic        s4_p_busy;
  logic [4:0]  s4_i_rd;
  logic [31:0] s4_i_result;
  logic        s4_i_load;
  logic [1:0]  s4_i_lsize;
  logic        s4_i_lsign;
  logic        s4_i_csr;
  logic        s4_i_trap;
  logic [5:0]  s4_i_cause;
  logic [31:0] s4_i_pc;
  logic        dmem_rvalid;
  logic        dmem_rerr;
  logic [31:0] dmem_rdata;
  logic        csr_rvalid;
  logic [31:0] csr_rdata;
  logic [4:0]  s4_rd;
  logic        s4_load;
  logic        s4_csr;
  logic        gpr_wen;
  logic [4:0]  gpr_rd;
  logic [31:0] gpr_wdata;
  logic        trap_raise;
  logic [5:0]  trap_cause;
  logic [31:0] trap_pc;

  int errors = 0;
  int checks = 0;

  always #5 g_clk = ~g_clk;

  frv_pipeline_retire dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .s4_p_valid(s4_p_valid), .s4_p_busy(s4_p_busy),
    .s4_i_rd(s4_i_rd), .s4_i_result(s4_i_result),
    .s4_i_load(s4_i_load), .s4_i_lsize(s4_i_lsize), .s4_i_lsign(s4_i_lsign),
    .s4_i_csr(s4_i_csr), .s4_i_trap(s4_i_trap), .s4_i_cause(s4_i_cause),
    .s4_i_pc(s4_i_pc),
    .dmem_rvalid(dmem_rvalid), .dmem_rerr(dmem_rerr), .dmem_rdata(dmem_rdata),
    .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata),
    .s4_rd(s4_rd), .s4_load(s4_load), .s4_csr(s4_csr),
    .gpr_wen(gpr_wen), .gpr_rd(gpr_rd), .gpr_wdata(gpr_wdata),
    .trap_raise(trap_raise), .trap_cause(trap_cause), .trap_pc(trap_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    s4_p_valid = 0; s4_i_rd = 0; s4_i_result = 0; s4_i_load = 0; s4_i_lsize = 0;
    s4_i_lsign = 0; s4_i_csr = 0; s4_i_trap = 0; s4_i_cause = 0; s4_i_pc = 0;
    dmem_rvalid = 0; dmem_rerr = 0; dmem_rdata = 0; csr_rvalid = 0; csr_rdata = 0;
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic start_load(input logic [4:0] rd, input logic [1:0] sz, input logic sg,
                            input logic [31:0] pc);
    clr();
    s4_p_valid = 1; s4_i_load = 1; s4_i_rd = rd; s4_i_lsize = sz; s4_i_lsign = sg; s4_i_pc = pc;
    cyc();
    clr();
  endtask

  task automatic load_resp(input string tag, input logic [4:0] rd, input logic [1:0] sz,
                           input logic sg, input logic [31:0] data, input logic [31:0] exp);
    start_load(rd, sz, sg, 32'h0);
    dmem_rvalid = 1; dmem_rdata = data;
    settle();
    chk({tag, "_wen"}, gpr_wen, 1'b1);
    chk({tag, "_rd"}, gpr_rd, rd);
    chk({tag, "_data"}, gpr_wdata, exp);
    cyc();
    clr();
  endtask

  initial begin
    int bad;
    clr();
    g_reset = 1;
    repeat (2) @(posedge g_clk);
    #1; settle();
    chk("rst_busy", s4_p_busy, 1'b0);
    chk("rst_s4_rd", s4_rd, 5'd0);
    chk("rst_load", s4_load, 1'b0);
    chk("rst_csr", s4_csr, 1'b0);
    chk("rst_wen", gpr_wen, 1'b0);
    chk("rst_wdata", gpr_wdata, 32'd0);
    chk("rst_trap", trap_raise, 1'b0);
    chk("rst_trap_pc", trap_pc, 32'd0);
    cyc();
    g_reset = 0;

    // back-to-back ALU results
    s4_p_valid = 1; s4_i_rd = 5'd3; s4_i_result = 32'hAAAA0001;
    settle();
    chk("alu0_busy", s4_p_busy, 1'b0);
    cyc();
    s4_i_rd = 5'd4; s4_i_result = 32'h5;
    settle();
    chk("alu0_wen", gpr_wen, 1'b1);
    chk("alu0_rd", gpr_rd, 5'd3);
    chk("alu0_data", gpr_wdata, 32'hAAAA0001);
    chk("alu1_busy", s4_p_busy, 1'b0);
    cyc();
    clr();
    settle();
    chk("alu1_wen", gpr_wen, 1'b1);
    chk("alu1_rd", gpr_rd, 5'd4);
    chk("alu1_data", gpr_wdata, 32'h5);
    cyc();
    settle();
    chk("alu_idle_wen", gpr_wen, 1'b0);
    chk("alu_idle_rd", s4_rd, 5'd0);

    // byte signed load, response after 3 wait cycles
    cyc();
    start_load(5'd7, 2'b00, 1'b1, 32'h40);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ldw_load", s4_load, 1'b1);
      chk("ldw_rd", s4_rd, 5'd7);
      chk("ldw_busy", s4_p_busy, 1'b1);
      chk("ldw_wen", gpr_wen, 1'b0);
      cyc();
    end
    dmem_rvalid = 1; dmem_rdata = 32'h000000F0;
    settle();
    chk("ldb_wen", gpr_wen, 1'b1);
    chk("ldb_rd", gpr_rd, 5'd7);
    chk("ldb_data", gpr_wdata, 32'hFFFFFFF0);
    cyc();
    clr();
    settle();
    chk("ldb_done_load", s4_load, 1'b0);
    chk("ldb_done_wen", gpr_wen, 1'b0);
    cyc();

    load_resp("ldh_u", 5'd8, 2'b01, 1'b0, 32'hFFFF8001, 32'h00008001);
    load_resp("ldh_s", 5'd8, 2'b01, 1'b1, 32'h00008001, 32'hFFFF8001);
    load_resp("ldb_u", 5'd9, 2'b00, 1'b0, 32'hFFFFFF85, 32'h00000085);
    load_resp("ldw", 5'd31, 2'b10, 1'b1, 32'h80000001, 32'h80000001);

    // load access fault: error wins over data
    start_load(5'd9, 2'b10, 1'b0, 32'h100);
    dmem_rvalid = 1; dmem_rerr = 1; dmem_rdata = 32'h55;
    settle();
    chk("lderr_wen", gpr_wen, 1'b0);
    chk("lderr_trap", trap_raise, 1'b1);
    chk("lderr_cause", trap_cause, 6'd5);
    chk("lderr_pc", trap_pc, 32'h100);
    cyc();
    clr();
    settle();
    chk("lderr_pulse", trap_raise, 1'b0);
    chk("lderr_idle", s4_load, 1'b0);
    cyc();

    // pre-trapped instruction: trap beats load
    s4_p_valid = 1; s4_i_trap = 1; s4_i_cause = 6'd2; s4_i_pc = 32'h200;
    s4_i_rd = 5'd6; s4_i_load = 1;
    cyc();
    clr();
    settle();
    chk("trap_raise", trap_raise, 1'b1);
    chk("trap_cause", trap_cause, 6'd2);
    chk("trap_pc", trap_pc, 32'h200);
    chk("trap_wen", gpr_wen, 1'b0);
    chk("trap_load", s4_load, 1'b0);
    cyc();
    settle();
    chk("trap_pulse", trap_raise, 1'b0);
    cyc();

    // CSR to x0, follow-up accept only after the response
    s4_p_valid = 1; s4_i_csr = 1; s4_i_rd = 5'd0;
    cyc();
    clr();
    settle();
    chk("csr_wait", s4_csr, 1'b1);
    chk("csr_busy", s4_p_busy, 1'b1);
    chk("csr_s4rd", s4_rd, 5'd0);
    cyc();
    csr_rvalid = 1; csr_rdata = 32'h1234;
    s4_p_valid = 1; s4_i_rd = 5'd5; s4_i_result = 32'h77;
    settle();
    chk("csr0_wen", gpr_wen, 1'b0);
    chk("csr0_still", s4_csr, 1'b1);
    chk("csr0_busy", s4_p_busy, 1'b1);
    cyc();
    csr_rvalid = 0; csr_rdata = 0;
    settle();
    chk("csr_next_busy", s4_p_busy, 1'b0);
    chk("csr_next_csr", s4_csr, 1'b0);
    cyc();
    clr();
    settle();
    chk("csr_next_wen", gpr_wen, 1'b1);
    chk("csr_next_rd", gpr_rd, 5'd5);
    chk("csr_next_data", gpr_wdata, 32'h77);
    cyc();

    s4_p_valid = 1; s4_i_csr = 1; s4_i_rd = 5'd10;
    cyc();
    clr();
    csr_rvalid = 1; csr_rdata = 32'hCAFE;
    settle();
    chk("csr10_wen", gpr_wen, 1'b1);
    chk("csr10_rd", gpr_rd, 5'd10);
    chk("csr10_data", gpr_wdata, 32'hCAFE);
    cyc();
    clr();

    // reset mid-WAIT_LD, then stray responses
    start_load(5'd11, 2'b10, 1'b0, 32'h80);
    settle();
    chk("rstld_load", s4_load, 1'b1);
    g_reset = 1;
    cyc();
    g_reset = 0;
    dmem_rvalid = 1; dmem_rdata = 32'hFF; csr_rvalid = 1; csr_rdata = 32'h9;
    settle();
    chk("rstld_load0", s4_load, 1'b0);
    chk("rstld_rd0", s4_rd, 5'd0);
    chk("rstld_wen", gpr_wen, 1'b0);
    chk("rstld_trap", trap_raise, 1'b0);
    chk("rstld_busy", s4_p_busy, 1'b0);
    cyc();
    clr();

`ifdef FRV_RETIRE_LD_TIMEOUT_EN
    start_load(5'd12, 2'b10, 1'b0, 32'h300);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      settle();
      if (trap_raise || !s4_load) bad++;
      cyc();
    end
    chk("to_early", bad, 0);
    settle();
    chk("to_trap", trap_raise, 1'b1);
    chk("to_cause", trap_cause, 6'd5);
    chk("to_pc", trap_pc, 32'h300);
    chk("to_wen", gpr_wen, 1'b0);
    cyc();
    settle();
    chk("to_idle", s4_load, 1'b0);
    cyc();

    start_load(5'd13, 2'b10, 1'b0, 32'h304);
    repeat (255) cyc();
    dmem_rvalid = 1; dmem_rdata = 32'h42;
    settle();
    chk("to_race_wen", gpr_wen, 1'b1);
    chk("to_race_data", gpr_wdata, 32'h42);
    chk("to_race_trap", trap_raise, 1'b0);
    cyc();
    clr();
`else
    start_load(5'd12, 2'b10, 1'b0, 32'h300);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      settle();
      if (trap_raise || !s4_load) bad++;
      cyc();
    end
    chk("nto_wait", bad, 0);
    dmem_rvalid = 1; dmem_rdata = 32'h42;
    settle();
    chk("nto_wen", gpr_wen, 1'b1);
    chk("nto_data", gpr_wdata, 32'h42);
    cyc();
    clr();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
